// File: rtl/dll_tx_scheduler_pkg.sv
// Shared types and default sizing for the DLL transmit scheduler.
//   DEF_*             : default widths and latency limits for the scheduler top
//   tx_sched_state_t  : packet-boundary / locked-source state
//   tx_src_t          : source selected for the current output beat
package dll_tx_scheduler_pkg;

    localparam int unsigned DEF_DATA_W        = 256;
    localparam int unsigned DEF_DLLP_W        = 64;
    localparam int unsigned DEF_ACK_LAT_LIMIT = 64;
    localparam int unsigned DEF_FC_LAT_LIMIT  = 512;
    localparam int unsigned DEF_AGE_W         = 10;

    typedef enum logic [1:0] {
        IDLE,
        SEND_RPL,
        SEND_TLP
    } tx_sched_state_t;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_RPL,
        SRC_TLP,
        SRC_ACK,
        SRC_FC
    } tx_src_t;

endpackage

// File: rtl/dll_tx_age_timer.sv
// Wait-age tracker for one DLLP request; flags the request urgent once it has
// waited LIMIT cycles without a grant.
//   sclk, sreset : clock, synchronous active-high reset
//   req_i        : request pending (held until granted)
//   gnt_i        : grant pulse for this request
//   urgent_o     : request pending and age >= LIMIT
module dll_tx_age_timer #(
    parameter int unsigned AGE_W = 10,
    parameter int unsigned LIMIT = 64
) (
    input  logic sclk,
    input  logic sreset,
    input  logic req_i,
    input  logic gnt_i,
    output logic urgent_o
);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [AGE_W-1:0] LIMIT_V = AGE_W'(LIMIT);

    logic [AGE_W-1:0] age;

    // Saturating age; cleared whenever the request is idle or served.
    always_ff @(posedge sclk) begin
        if (sreset || !req_i || gnt_i) begin
            age <= '0;
        end else if (age != AGE_MAX) begin
            age <= age + AGE_W'(1);
        end
    end

    assign urgent_o = req_i && (age >= LIMIT_V);

endmodule

// File: rtl/dll_tx_scheduler.sv
// Data Link Layer transmit scheduler: shares one PIPE beat slot between
// replayed TLPs, new TLPs, ACK/NAK DLLPs and UpdateFC DLLPs. TLPs run to
// completion once started; aged DLLPs overtake new TLPs at packet boundaries.
//   sclk, sreset                     : clock, synchronous active-high reset
//   ack_req_i/ack_dllp_i/ack_gnt_o   : ACK/NAK DLLP request, content, grant pulse
//   fc_req_i/fc_dllp_i/fc_gnt_o      : UpdateFC DLLP request, content, grant pulse
//   rpl_valid_i/data/eop/rpl_ready_o : replay TLP beat stream
//   tlp_valid_i/data/eop/tlp_ready_o : new TLP beat stream
//   tx_valid_o/tx_data_o/tx_is_dllp_o: registered output beat
//   tx_ready_i                       : framer accepts the output beat
module dll_tx_scheduler
    import dll_tx_scheduler_pkg::*;
#(
    parameter int unsigned DATA_W        = DEF_DATA_W,
    parameter int unsigned DLLP_W        = DEF_DLLP_W,
    parameter int unsigned ACK_LAT_LIMIT = DEF_ACK_LAT_LIMIT,
    parameter int unsigned FC_LAT_LIMIT  = DEF_FC_LAT_LIMIT,
    parameter int unsigned AGE_W         = DEF_AGE_W
) (
    input  logic              sclk,
    input  logic              sreset,
    input  logic              ack_req_i,
    input  logic [DLLP_W-1:0] ack_dllp_i,
    output logic              ack_gnt_o,
    input  logic              fc_req_i,
    input  logic [DLLP_W-1:0] fc_dllp_i,
    output logic              fc_gnt_o,
    input  logic              rpl_valid_i,
    input  logic [DATA_W-1:0] rpl_data_i,
    input  logic              rpl_eop_i,
    output logic              rpl_ready_o,
    input  logic              tlp_valid_i,
    input  logic [DATA_W-1:0] tlp_data_i,
    input  logic              tlp_eop_i,
    output logic              tlp_ready_o,
    output logic              tx_valid_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_is_dllp_o,
    input  logic              tx_ready_i
);

    tx_sched_state_t state;
    tx_sched_state_t state_nxt;
    tx_src_t         sel;
    logic            load_en;
    logic            ack_urgent;
    logic            fc_urgent;

    assign load_en = !tx_valid_o || tx_ready_i;

    dll_tx_age_timer #(
        .AGE_W (AGE_W),
        .LIMIT (ACK_LAT_LIMIT)
    ) u_ack_age (
        .sclk     (sclk),
        .sreset   (sreset),
        .req_i    (ack_req_i),
        .gnt_i    (ack_gnt_o),
        .urgent_o (ack_urgent)
    );

    dll_tx_age_timer #(
        .AGE_W (AGE_W),
        .LIMIT (FC_LAT_LIMIT)
    ) u_fc_age (
        .sclk     (sclk),
        .sreset   (sreset),
        .req_i    (fc_req_i),
        .gnt_i    (fc_gnt_o),
        .urgent_o (fc_urgent)
    );

    // Source selection and next state; nothing is selected while the output
    // register cannot load, so handshakes never fire during a stall.
    always_comb begin
        sel       = SRC_NONE;
        state_nxt = state;
        if (load_en && !sreset) begin
            case (state)
                IDLE: begin
                    if (rpl_valid_i)      sel = SRC_RPL;
                    else if (ack_urgent)  sel = SRC_ACK;
                    else if (fc_urgent)   sel = SRC_FC;
                    else if (tlp_valid_i) sel = SRC_TLP;
                    else if (ack_req_i)   sel = SRC_ACK;
                    else if (fc_req_i)    sel = SRC_FC;
                end
                SEND_RPL: if (rpl_valid_i) sel = SRC_RPL;
                SEND_TLP: if (tlp_valid_i) sel = SRC_TLP;
                default:  state_nxt = IDLE;
            endcase
        end
        // A TLP beat with eop closes the packet, including single-beat TLPs.
        case (sel)
            SRC_RPL: state_nxt = rpl_eop_i ? IDLE : SEND_RPL;
            SRC_TLP: state_nxt = tlp_eop_i ? IDLE : SEND_TLP;
            default: ;
        endcase
    end

    assign rpl_ready_o = (sel == SRC_RPL);
    assign tlp_ready_o = (sel == SRC_TLP);
    assign ack_gnt_o   = (sel == SRC_ACK);
    assign fc_gnt_o    = (sel == SRC_FC);

    // State register.
    always_ff @(posedge sclk) begin
        if (sreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Output beat register; data is held when the slot goes empty.
    always_ff @(posedge sclk) begin
        if (sreset) begin
            tx_valid_o   <= 1'b0;
            tx_data_o    <= '0;
            tx_is_dllp_o <= 1'b0;
        end else if (load_en) begin
            tx_valid_o   <= (sel != SRC_NONE);
            tx_is_dllp_o <= (sel == SRC_ACK) || (sel == SRC_FC);
            case (sel)
                SRC_RPL: tx_data_o <= rpl_data_i;
                SRC_TLP: tx_data_o <= tlp_data_i;
                SRC_ACK: tx_data_o <= DATA_W'(ack_dllp_i);
                SRC_FC:  tx_data_o <= DATA_W'(fc_dllp_i);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dll_tx_scheduler.sv
// Randomized bench for dll_tx_scheduler with a behavioural cycle model of the
// scheduling rules (locked packet source, ranked boundary rules, wait ages).
module tb_dll_tx_scheduler;

    localparam int unsigned DATA_W = 256;
    localparam int unsigned DLLP_W = 64;
    localparam int ACK_LIM = 4;
    localparam int FC_LIM  = 8;
    localparam int AGE_MAX = 1023;
    localparam int S_NONE = 0, S_RPL = 1, S_TLP = 2, S_ACK = 3, S_FC = 4;

    logic              sclk = 1'b0;
    logic              sreset;
    logic              ack_req_i, fc_req_i;
    logic [DLLP_W-1:0] ack_dllp_i, fc_dllp_i;
    logic              ack_gnt_o, fc_gnt_o;
    logic              rpl_valid_i, rpl_eop_i, rpl_ready_o;
    logic              tlp_valid_i, tlp_eop_i, tlp_ready_o;
    logic [DATA_W-1:0] rpl_data_i, tlp_data_i;
    logic              tx_valid_o, tx_is_dllp_o, tx_ready_i;
    logic [DATA_W-1:0] tx_data_o;

    always #5 sclk = ~sclk;

    dll_tx_scheduler #(
        .DATA_W        (DATA_W),
        .DLLP_W        (DLLP_W),
        .ACK_LAT_LIMIT (ACK_LIM),
        .FC_LAT_LIMIT  (FC_LIM),
        .AGE_W         (10)
    ) dut (
        .sclk         (sclk),
        .sreset       (sreset),
        .ack_req_i    (ack_req_i),
        .ack_dllp_i   (ack_dllp_i),
        .ack_gnt_o    (ack_gnt_o),
        .fc_req_i     (fc_req_i),
        .fc_dllp_i    (fc_dllp_i),
        .fc_gnt_o     (fc_gnt_o),
        .rpl_valid_i  (rpl_valid_i),
        .rpl_data_i   (rpl_data_i),
        .rpl_eop_i    (rpl_eop_i),
        .rpl_ready_o  (rpl_ready_o),
        .tlp_valid_i  (tlp_valid_i),
        .tlp_data_i   (tlp_data_i),
        .tlp_eop_i    (tlp_eop_i),
        .tlp_ready_o  (tlp_ready_o),
        .tx_valid_o   (tx_valid_o),
        .tx_data_o    (tx_data_o),
        .tx_is_dllp_o (tx_is_dllp_o),
        .tx_ready_i   (tx_ready_i)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model state
    logic              m_valid, m_dllp;
    logic [DATA_W-1:0] m_data;
    int                m_lock;
    int                m_ack_age, m_fc_age;
    int                win;

    // Stimulus knobs
    int p_start [2];
    int p_cont, p_ack, p_fc, p_ready, p_rst_pm, max_len, cyc;
    bit stall_mode;

    // Packet sources: index 0 = replay, 1 = new TLP
    logic              s_valid [2];
    logic              s_eop   [2];
    logic [DATA_W-1:0] s_data  [2];
    bit                in_pkt  [2];
    int                left    [2];
    bit                fired   [2];

    assign rpl_valid_i = s_valid[0];
    assign rpl_eop_i   = s_eop[0];
    assign rpl_data_i  = s_data[0];
    assign tlp_valid_i = s_valid[1];
    assign tlp_eop_i   = s_eop[1];
    assign tlp_data_i  = s_data[1];

    function automatic logic [DATA_W-1:0] rand_beat();
        logic [DATA_W-1:0] d;
        for (int k = 0; k < int'(DATA_W / 32); k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    // Who owns the next output beat, from the scheduling rules.
    task automatic model_pick(output int w);
        int order [6];
        bit cond  [6];
        bit load;
        load  = !m_valid || tx_ready_i;
        w     = S_NONE;
        order = '{S_RPL, S_ACK, S_FC, S_TLP, S_ACK, S_FC};
        cond  = '{rpl_valid_i,
                  ack_req_i && (m_ack_age >= ACK_LIM),
                  fc_req_i && (m_fc_age >= FC_LIM),
                  tlp_valid_i,
                  ack_req_i,
                  fc_req_i};
        if (load && !sreset) begin
            if (m_lock == S_RPL)      w = rpl_valid_i ? S_RPL : S_NONE;
            else if (m_lock == S_TLP) w = tlp_valid_i ? S_TLP : S_NONE;
            else begin
                for (int i = 0; i < 6; i++)
                    if (w == S_NONE && cond[i]) w = order[i];
            end
        end
    endtask

    // Compare this cycle, then advance the model across the coming edge.
    task automatic check_and_step();
        logic [3:0] hs;
        bit load;
        load = !m_valid || tx_ready_i;
        check("tx_valid",   DATA_W'(tx_valid_o),   DATA_W'(m_valid));
        check("tx_is_dllp", DATA_W'(tx_is_dllp_o), DATA_W'(m_dllp));
        if (m_valid) check("tx_data", tx_data_o, m_data);
        model_pick(win);
        hs = {win == S_RPL, win == S_TLP, win == S_ACK, win == S_FC};
        check("handshake", DATA_W'({rpl_ready_o, tlp_ready_o, ack_gnt_o, fc_gnt_o}), DATA_W'(hs));
        fired[0] = (win == S_RPL);
        fired[1] = (win == S_TLP);
        if (sreset) begin
            m_valid = 0; m_dllp = 0; m_data = '0; m_lock = S_NONE;
            m_ack_age = 0; m_fc_age = 0;
        end else begin
            if (load) begin
                m_valid = (win != S_NONE);
                m_dllp  = (win == S_ACK) || (win == S_FC);
                case (win)
                    S_RPL: begin m_data = rpl_data_i; m_lock = rpl_eop_i ? S_NONE : S_RPL; end
                    S_TLP: begin m_data = tlp_data_i; m_lock = tlp_eop_i ? S_NONE : S_TLP; end
                    S_ACK: m_data = DATA_W'(ack_dllp_i);
                    S_FC:  m_data = DATA_W'(fc_dllp_i);
                    default: ;
                endcase
            end
            m_ack_age = (!ack_req_i || win == S_ACK) ? 0 : ((m_ack_age < AGE_MAX) ? m_ack_age + 1 : AGE_MAX);
            m_fc_age  = (!fc_req_i  || win == S_FC)  ? 0 : ((m_fc_age  < AGE_MAX) ? m_fc_age  + 1 : AGE_MAX);
        end
    endtask

    // New input values just after the edge, honouring the handshakes that fired.
    task automatic drive_next();
        bit was_rst;
        was_rst = sreset;
        for (int s = 0; s < 2; s++) begin
            bit newpkt;
            newpkt = 0;
            if (was_rst) in_pkt[s] = 0;
            else if (fired[s]) begin
                left[s]--;
                if (left[s] == 0) in_pkt[s] = 0;
            end
            if (!in_pkt[s] && ($urandom % 100) < p_start[s]) begin
                in_pkt[s] = 1;
                left[s]   = $urandom_range(1, max_len);
                newpkt    = 1;
            end
            if (fired[s] || newpkt) s_data[s] = rand_beat();
            s_valid[s] = in_pkt[s] && (($urandom % 100) < p_cont);
            s_eop[s]   = in_pkt[s] && (left[s] == 1);
        end
        if (!was_rst && win == S_ACK) ack_req_i = 0;
        if (!ack_req_i && ($urandom % 100) < p_ack) begin
            ack_req_i  = 1;
            ack_dllp_i = {$urandom, $urandom};
        end
        if (!was_rst && win == S_FC) fc_req_i = 0;
        if (!fc_req_i && ($urandom % 100) < p_fc) begin
            fc_req_i  = 1;
            fc_dllp_i = {$urandom, $urandom};
        end
        cyc++;
        if (stall_mode) tx_ready_i = (cyc % 25) >= 10;
        else            tx_ready_i = ($urandom % 100) < p_ready;
        sreset = ($urandom % 1000) < p_rst_pm;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sclk);
            check_and_step();
            @(posedge sclk);
            #1;
            drive_next();
        end
    endtask

    task automatic set_knobs(input int pr, input int pt, input int pc, input int pa,
                             input int pf, input int prdy, input int prst, input int ml,
                             input bit stl);
        p_start[0] = pr; p_start[1] = pt; p_cont = pc; p_ack = pa; p_fc = pf;
        p_ready = prdy; p_rst_pm = prst; max_len = ml; stall_mode = stl;
    endtask

    initial begin
        sreset = 1; ack_req_i = 0; fc_req_i = 0; ack_dllp_i = '0; fc_dllp_i = '0;
        tx_ready_i = 0; cyc = 0; win = S_NONE;
        for (int s = 0; s < 2; s++) begin
            s_valid[s] = 0; s_eop[s] = 0; s_data[s] = '0;
            in_pkt[s] = 0; left[s] = 0; fired[s] = 0;
        end
        m_valid = 0; m_dllp = 0; m_data = '0; m_lock = S_NONE;
        m_ack_age = 0; m_fc_age = 0;
        @(posedge sclk);
        #1;
        // Reset held: outputs and handshakes must stay at zero.
        set_knobs(0, 0, 100, 0, 0, 100, 1000, 4, 0);
        run_cycles(3);
        // General mix with occasional mid-packet resets.
        set_knobs(15, 50, 90, 20, 10, 80, 5, 4, 0);
        run_cycles(1500);
        // Back-to-back single-beat TLPs with DLLPs always pending: urgency path.
        set_knobs(0, 100, 100, 100, 100, 100, 0, 1, 0);
        run_cycles(800);
        // Long TLPs against periodic 10-cycle framer stalls.
        set_knobs(10, 80, 95, 30, 30, 100, 0, 4, 1);
        run_cycles(1200);
        // Replay-heavy traffic competing with new TLPs.
        set_knobs(40, 70, 85, 15, 15, 70, 2, 3, 0);
        run_cycles(1500);
        // Quiet link: no sources, output must go idle.
        set_knobs(0, 0, 100, 0, 0, 100, 0, 1, 0);
        run_cycles(20);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
